dac_play_sequencer: RTL and testbench

- Playback controller for a DAC output stream: sequences a waveform BRAM of 128-bit beats (8 x 16-bit samples) onto the AXI4-Stream DAC input.
- Handles start/stop, programmable waveform length and loop count, and a constant idle word when not playing.
- Sits between the register interface and the DAC transfer stage. The DAC consumes continuously, so tvalid is always high after reset.

---
 rtl/dac_play_sequencer.sv | 151 +++++++++++++++
 tb/tb_dac_play_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_play_sequencer.sv
// Playback sequencer: streams a BRAM waveform of 8x16-bit beats onto the DAC AXI4-Stream input.
// Optional macro DAC_PLAY_MARKER_EN adds m_axis_tuser, high on the beat carrying address 0 of each pass.
module dac_play_sequencer #(
  parameter int unsigned DWIDTH_OUT  = 128,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned LOOP_WIDTH  = 16,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [ADDR_WIDTH-1:0] cfg_length,
  input  logic [LOOP_WIDTH-1:0] cfg_loops,
  input  logic [15:0]           cfg_idle,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  input  logic [DWIDTH_OUT-1:0] mem_rdata,
  output logic [DWIDTH_OUT-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
`ifdef DAC_PLAY_MARKER_EN
  output logic                  m_axis_tuser,
`endif
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  len_q;
  logic [LOOP_WIDTH-1:0]  loop_q;
  logic [LOOP_WIDTH-1:0]  loops_q;
  logic [MEM_LATENCY-1:0] tag_q;
  logic [MEM_LATENCY-1:0] tag_d;
  logic [DWIDTH_OUT-1:0]  tdata_q;
  logic                   tvalid_q;
  logic                   busy_q;
  logic                   done_q;
`ifdef DAC_PLAY_MARKER_EN
  logic [MEM_LATENCY-1:0] mark_q;
  logic [MEM_LATENCY-1:0] mark_d;
  logic                   tuser_q;
`endif

  logic                  adv;
  logic                  issue;
  logic                  at_end;
  logic                  last_pass;
  logic [DWIDTH_OUT-1:0] idle_beat;

  assign adv       = m_axis_tready;
  assign issue     = adv && (state_q == ST_RUN) && !cfg_stop;
  assign at_end    = (addr_q == len_q);
  assign last_pass = (loops_q != '0) && (loop_q == loops_q - LOOP_WIDTH'(1));
  assign idle_beat = {(DWIDTH_OUT/16){cfg_idle}};

  // BRAM stages keep moving in DRAIN so reads already in flight reach the output register.
  assign mem_en = adv && (state_q != ST_IDLE);

  always_comb begin
    tag_d    = tag_q << 1;
    tag_d[0] = issue;
`ifdef DAC_PLAY_MARKER_EN
    mark_d    = mark_q << 1;
    mark_d[0] = issue && (addr_q == '0);
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      loop_q   <= '0;
      loops_q  <= '0;
      tag_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DAC_PLAY_MARKER_EN
      mark_q   <= '0;
      tuser_q  <= 1'b0;
`endif
    end else begin
      tvalid_q <= 1'b1;
      done_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          tdata_q <= idle_beat;
`ifdef DAC_PLAY_MARKER_EN
          tuser_q <= 1'b0;
`endif
          if (cfg_start && !cfg_stop) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
            loop_q  <= '0;
            len_q   <= cfg_length;
            loops_q <= cfg_loops;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (adv) begin
            tag_q   <= tag_d;
            tdata_q <= tag_q[MEM_LATENCY-1] ? mem_rdata : idle_beat;
`ifdef DAC_PLAY_MARKER_EN
            mark_q  <= mark_d;
            tuser_q <= tag_q[MEM_LATENCY-1] && mark_q[MEM_LATENCY-1];
`endif
          end
          if (state_q == ST_RUN) begin
            if (cfg_stop) begin
              state_q <= ST_DRAIN;
            end else if (adv) begin
              if (at_end) begin
                addr_q <= '0;
                if (loop_q != '1) loop_q <= loop_q + LOOP_WIDTH'(1);
                if (last_pass) state_q <= ST_DRAIN;
              end else begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
              end
            end
          end else if (tag_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr      = addr_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
`ifdef DAC_PLAY_MARKER_EN
  assign m_axis_tuser  = tuser_q;
`endif

endmodule

// File: tb/tb_dac_play_sequencer.sv
// Self-checking bench for dac_play_sequencer: BRAM model, stream collector and a pass/beat list model.
module tb_dac_play_sequencer;
  localparam int unsigned DW = 128;
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 16;
  localparam int unsigned ML = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_stop = 1'b0;
  logic [AW-1:0] cfg_length = '0;
  logic [LW-1:0] cfg_loops = '0;
  logic [15:0]   cfg_idle = 16'hA5A5;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          busy;
  logic          done;
  logic          tuser_s;

  int nvec = 0;
  int nerr = 0;

  always #5 aclk = ~aclk;

  dac_play_sequencer #(
    .DWIDTH_OUT (DW),
    .ADDR_WIDTH (AW),
    .LOOP_WIDTH (LW),
    .MEM_LATENCY(ML)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_start    (cfg_start),
    .cfg_stop     (cfg_stop),
    .cfg_length   (cfg_length),
    .cfg_loops    (cfg_loops),
    .cfg_idle     (cfg_idle),
    .mem_addr     (mem_addr),
    .mem_en       (mem_en),
    .mem_rdata    (mem_rdata),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
`ifdef DAC_PLAY_MARKER_EN
    .m_axis_tuser (tuser_s),
`endif
    .busy         (busy),
    .done         (done)
  );
`ifndef DAC_PLAY_MARKER_EN
  assign tuser_s = 1'b0;
`endif

  logic [DW-1:0] idle_beat;
  assign idle_beat = {8{cfg_idle}};

  // BRAM: ML enabled cycles from address to read data
  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] st  [ML];
  always @(posedge aclk) begin
    if (mem_en) begin
      st[0] <= mem[mem_addr[4:0]];
      for (int k = 1; k < ML; k++) st[k] <= st[k-1];
    end
  end
  assign mem_rdata = st[ML-1];

  // Collector: every beat accepted by the DAC that is not the idle word
  logic          adv_seen = 1'b0;
  logic [DW-1:0] got[$];
  bit            got_user[$];
  int            done_cnt = 0;
  int            en_bad = 0;
  always @(posedge aclk) adv_seen <= m_axis_tready;
  always @(negedge aclk) begin
    #1;
    if (!m_axis_tready && mem_en) en_bad++;
    if (done) done_cnt++;
    if (aresetn && adv_seen && m_axis_tdata !== idle_beat) begin
      got.push_back(m_axis_tdata);
      got_user.push_back(tuser_s);
    end
  end

  task automatic fill_mem(input bit rnd);
    for (int k = 0; k < 32; k++)
      mem[k] = rnd ? {$urandom, $urandom, $urandom, $urandom} : {8{16'h0100 + 16'(k)}};
  endtask

  // mode: 0 tready=1, 1 pattern 1,0,0, 2 random; poke>=0 pulses start at that cycle
  task automatic run_play(input int len, input int loops, input int mode, input bit scramble,
                          input int poke, output bit to);
    int phase = 0;
    @(negedge aclk);
    got.delete(); got_user.delete(); done_cnt = 0; en_bad = 0;
    cfg_length = AW'(len); cfg_loops = LW'(loops); cfg_start = 1'b1; m_axis_tready = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      case (mode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = (phase % 3 == 0);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      phase++;
      cfg_start = (c == poke);
      if (scramble) begin cfg_length = AW'($urandom); cfg_loops = LW'($urandom); end
      @(negedge aclk);
      if (done_cnt > 0) begin to = 1'b0; break; end
    end
    cfg_start = 1'b0; m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
  endtask

  // Compares the collected stream against loops passes of beats 0..len
  task automatic check_stream(input string name, input int len, input int loops, input bit to);
    logic [DW-1:0] exp[$];
    bit            exp_u[$];
    for (int p = 0; p < loops; p++)
      for (int k = 0; k <= len; k++) begin exp.push_back(mem[k]); exp_u.push_back(k == 0); end
    nvec++;
    if (to !== 1'b0) begin nerr++; $display("FAIL %s timeout: no done pulse", name); end
    nvec++;
    if (got.size() !== exp.size()) begin
      nerr++; $display("FAIL %s count: got %0d beats, expected %0d", name, got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      nvec++;
      if (got[i] !== exp[i]) begin
        nerr++; $display("FAIL %s beat %0d: got %h expected %h", name, i, got[i], exp[i]);
      end
`ifdef DAC_PLAY_MARKER_EN
      nvec++;
      if (got_user[i] !== exp_u[i]) begin
        nerr++; $display("FAIL %s tuser %0d: got %b expected %b", name, i, got_user[i], exp_u[i]);
      end
`endif
    end
    nvec++;
    if (done_cnt !== 1) begin nerr++; $display("FAIL %s done pulses: got %0d expected 1", name, done_cnt); end
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL %s busy after done: got %b expected 0", name, busy); end
    nvec++;
    if (en_bad !== 0) begin nerr++; $display("FAIL %s mem_en with tready=0: %0d cycles, expected 0", name, en_bad); end
  endtask

  task automatic test_reset;
    #1 aresetn = 1'b0;
    #2;
    nvec++; if (m_axis_tdata !== '0) begin nerr++; $display("FAIL rst tdata: got %h expected 0", m_axis_tdata); end
    nvec++; if (m_axis_tvalid !== 1'b0) begin nerr++; $display("FAIL rst tvalid: got %b expected 0", m_axis_tvalid); end
    nvec++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL rst busy/done: got %b/%b expected 0/0", busy, done); end
    nvec++; if (mem_en !== 1'b0 || mem_addr !== '0) begin nerr++; $display("FAIL rst mem: en %b addr %0d expected 0/0", mem_en, mem_addr); end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    nvec++; if (m_axis_tvalid !== 1'b1) begin nerr++; $display("FAIL rst release tvalid: got %b expected 1", m_axis_tvalid); end
    nvec++; if (m_axis_tdata !== idle_beat) begin nerr++; $display("FAIL rst release tdata: got %h expected %h", m_axis_tdata, idle_beat); end
  endtask

  task automatic test_basic;
    logic [DW-1:0] e;
    @(negedge aclk);
    fill_mem(1'b0);
    cfg_length = AW'(3); cfg_loops = LW'(2); m_axis_tready = 1'b1; cfg_start = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge aclk);
      cfg_start = 1'b0;
      e = (n >= ML + 2 && n < ML + 2 + 8) ? mem[(n - ML - 2) % 4] : idle_beat;
      nvec++;
      if (m_axis_tdata !== e) begin nerr++; $display("FAIL basic tdata cyc %0d: got %h expected %h", n, m_axis_tdata, e); end
      nvec++;
      if (done !== (n == ML + 2 + 8)) begin nerr++; $display("FAIL basic done cyc %0d: got %b", n, done); end
      nvec++;
      if (busy !== (n < ML + 2 + 8)) begin nerr++; $display("FAIL basic busy cyc %0d: got %b", n, busy); end
    end
  endtask

  task automatic test_backpressure;
    bit to;
    fill_mem(1'b0);
    run_play(5, 2, 1, 1'b0, -1, to);
    check_stream("bp", 5, 2, to);
  endtask

  task automatic test_len0;
    bit to;
    fill_mem(1'b1);
    run_play(0, 3, 2, 1'b0, -1, to);
    check_stream("len0", 0, 3, to);
  endtask

  task automatic test_random;
    bit to;
    int len, loops;
    for (int it = 0; it < 6; it++) begin
      fill_mem(1'b1);
      len = $urandom_range(0, 15);
      loops = $urandom_range(1, 3);
      run_play(len, loops, $urandom_range(0, 2), it[0], -1, to);
      cfg_length = '0; cfg_loops = '0;
      check_stream($sformatf("rnd%0d", it), len, loops, to);
    end
  endtask

  task automatic test_collisions;
    bit to;
    @(negedge aclk);
    cfg_start = 1'b1; cfg_stop = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0; cfg_stop = 1'b0;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL collide busy: got %b expected 0", busy); end
    @(negedge aclk);
    nvec++; if (busy !== 1'b0 || m_axis_tdata !== idle_beat) begin
      nerr++; $display("FAIL collide idle: busy %b tdata %h expected 0/%h", busy, m_axis_tdata, idle_beat);
    end
    fill_mem(1'b0);
    run_play(2, 2, 0, 1'b0, 3, to);
    check_stream("start_in_run", 2, 2, to);
  endtask

  task automatic test_stop;
    int issued = 0;
    bit to = 1'b1;
    @(negedge aclk);
    fill_mem(1'b1);
    got.delete(); got_user.delete(); done_cnt = 0; en_bad = 0;
    cfg_length = AW'(7); cfg_loops = '0; m_axis_tready = 1'b1; cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (issued == 20) begin
        cfg_stop = 1'b1; @(negedge aclk); cfg_stop = 1'b0; to = 1'b0; break;
      end
      if (mem_en) issued++;
      @(negedge aclk);
    end
    for (int c = 0; c < 50 && done_cnt == 0; c++) @(negedge aclk);
    repeat (3) @(negedge aclk);
    if (done_cnt == 0) to = 1'b1;
    // 20 beats = 2.5 passes of an 8-beat waveform
    nvec++;
    if (got.size() !== 20) begin nerr++; $display("FAIL stop count: got %0d expected 20", got.size()); end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      nvec++;
      if (got[i] !== mem[i % 8]) begin nerr++; $display("FAIL stop beat %0d: got %h expected %h", i, got[i], mem[i % 8]); end
    end
    nvec++; if (to !== 1'b0) begin nerr++; $display("FAIL stop timeout: no done"); end
    nvec++; if (done_cnt !== 1) begin nerr++; $display("FAIL stop done pulses: got %0d expected 1", done_cnt); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL stop busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midplay;
    @(negedge aclk);
    fill_mem(1'b1);
    cfg_length = AW'(7); cfg_loops = '0; m_axis_tready = 1'b1; cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    repeat (6) @(negedge aclk);
    done_cnt = 0;
    @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    nvec++; if (m_axis_tdata !== '0) begin nerr++; $display("FAIL midrst tdata: got %h expected 0", m_axis_tdata); end
    nvec++; if (m_axis_tvalid !== 1'b0) begin nerr++; $display("FAIL midrst tvalid: got %b expected 0", m_axis_tvalid); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL midrst busy: got %b expected 0", busy); end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    nvec++; if (m_axis_tvalid !== 1'b1) begin nerr++; $display("FAIL midrst release tvalid: got %b expected 1", m_axis_tvalid); end
    nvec++; if (m_axis_tdata !== idle_beat) begin nerr++; $display("FAIL midrst release tdata: got %h expected %h", m_axis_tdata, idle_beat); end
    repeat (4) @(negedge aclk);
    nvec++; if (done_cnt !== 0 || busy !== 1'b0) begin nerr++; $display("FAIL midrst done/busy: got %0d/%b expected 0/0", done_cnt, busy); end
  endtask

`ifdef DAC_PLAY_MARKER_EN
  task automatic test_marker;
    bit to;
    fill_mem(1'b0);
    run_play(1, 3, 0, 1'b0, -1, to);
    check_stream("marker", 1, 3, to);
    for (int i = 0; i < 6 && i < got_user.size(); i++) begin
      nvec++;
      if (got_user[i] !== (i % 2 == 0)) begin nerr++; $display("FAIL marker pat %0d: got %b expected %b", i, got_user[i], i % 2 == 0); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_collisions();
    test_stop();
    test_backpressure();
    test_len0();
    test_random();
`ifdef DAC_PLAY_MARKER_EN
    test_marker();
`endif
    test_reset_midplay();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
